// File: rtl/scr_stack_ctrl.sv
// scr_stack_ctrl
// Stack-pointer controller between the MCU control FSM and the scratch RAM.
// It carries out PUSH, POP and LOAD_SP requests, owns the stack pointer and
// flags overflow and underflow. The stack is full-descending from SP_BASE:
// PUSH pre-decrements SP and writes at the new SP, POP reads at SP and then
// post-increments it.
//
// Handshakes: an operation transfers on a rising edge where OP_VALID and
// OP_READY are both high. A POP result transfers on a rising edge where
// RESP_VALID and RESP_READY are both high. While RESP_VALID is high,
// RESP_DATA is held constant until that transfer happens.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   OP_VALID/OP_READY operation handshake, OP selects PUSH/POP/LOAD_SP
//   OP                00 PUSH, 01 POP, 10 LOAD_SP, 11 no-op
//   PUSH_DATA, SP_IN  PUSH payload, LOAD_SP value
//   RESP_*            POP result handshake and data
//   DONE, OVF, UNF    one-cycle completion / rejection pulses
//   SP_OUT            current stack pointer
//   EMPTY, FULL       occupancy flags
//   SCR_*             scratch RAM port (combinational read data in)
//   STATE_DBG         current FSM state, for debug and checkers
module scr_stack_ctrl #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 10,
  parameter logic [ADDR_W-1:0] SP_BASE     = '0,
  parameter int                STACK_DEPTH = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              OP_VALID,
  input  logic [1:0]        OP,
  output logic              OP_READY,
  input  logic [DATA_W-1:0] PUSH_DATA,
  input  logic [ADDR_W-1:0] SP_IN,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic [DATA_W-1:0] RESP_DATA,
  output logic              DONE,
  output logic              OVF,
  output logic              UNF,
  output logic [ADDR_W-1:0] SP_OUT,
  output logic              EMPTY,
  output logic              FULL,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic              SCR_WE,
  output logic [DATA_W-1:0] SCR_DATA_OUT,
  input  logic [DATA_W-1:0] SCR_DATA_IN,
  output logic [1:0]        STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PUSH_WR = 2'd1,
    S_POP_RD  = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0]        OP_PUSH    = 2'b00;
  localparam logic [1:0]        OP_POP     = 2'b01;
  localparam logic [1:0]        OP_LOAD_SP = 2'b10;
  localparam logic [ADDR_W-1:0] DEPTH      = ADDR_W'(STACK_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] occ;
  logic [DATA_W-1:0] push_data_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              done_q;
  logic              ovf_q;
  logic              unf_q;

  // Occupancy is derived from SP alone so that LOAD_SP to any value keeps
  // the flags consistent; the subtraction wraps at 2^ADDR_W.
  assign occ   = SP_BASE - sp;
  assign EMPTY = (occ == '0);
  assign FULL  = (occ >= DEPTH);

  // Port-side outputs decode directly from the state and SP flops, so an
  // asynchronous reset during PUSH_WR drops SCR_WE immediately.
  assign OP_READY     = (state == S_IDLE);
  assign RESP_VALID   = (state == S_RESP);
  assign SCR_WE       = (state == S_PUSH_WR);
  assign SCR_ADDR     = (state == S_PUSH_WR) ? sp - ADDR_W'(1) : sp;
  assign SCR_DATA_OUT = push_data_q;
  assign RESP_DATA    = resp_data_q;
  assign SP_OUT       = sp;
  assign DONE         = done_q;
  assign OVF          = ovf_q;
  assign UNF          = unf_q;
  assign STATE_DBG    = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      sp          <= SP_BASE;
      push_data_q <= '0;
      resp_data_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses.
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (OP_VALID) begin
            case (OP)
              OP_PUSH: begin
                if (FULL) begin
                  ovf_q <= 1'b1;
                end else begin
                  push_data_q <= PUSH_DATA;
                  state       <= S_PUSH_WR;
                end
              end
              OP_POP: begin
                if (EMPTY) begin
                  // Rejected POP still answers, with zero data, so the
                  // consumer handshake always completes.
                  unf_q       <= 1'b1;
                  resp_data_q <= '0;
                  state       <= S_RESP;
                end else begin
                  state <= S_POP_RD;
                end
              end
              OP_LOAD_SP: begin
                sp     <= SP_IN;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_PUSH_WR: begin
          sp     <= sp - ADDR_W'(1);
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        S_POP_RD: begin
          resp_data_q <= SCR_DATA_IN;
          sp          <= sp + ADDR_W'(1);
          state       <= S_RESP;
        end
        S_RESP: begin
          if (RESP_READY) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr_stack_ctrl.sv
module tb_scr_stack_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       op_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [9:0] push_data = '0;
  logic [7:0] sp_in = '0;
  logic       resp_ready = 1'b0;
  logic       sel = 1'b0;  // 0: default-depth DUT, 1: depth-4 DUT

  // ---------------- DUT A (STACK_DEPTH = 255) ----------------
  logic       a_op_ready, a_resp_valid, a_done, a_ovf, a_unf, a_empty, a_full, a_we;
  logic [9:0] a_resp_data, a_wdata, a_rdata;
  logic [7:0] a_sp, a_addr;
  logic [1:0] a_state;
  logic [9:0] mem_a [256];

  scr_stack_ctrl u_dut_a (
    .CLK(clk), .RST_N(rst_n), .OP_VALID(op_valid), .OP(op), .OP_READY(a_op_ready),
    .PUSH_DATA(push_data), .SP_IN(sp_in), .RESP_VALID(a_resp_valid),
    .RESP_READY(resp_ready), .RESP_DATA(a_resp_data), .DONE(a_done), .OVF(a_ovf),
    .UNF(a_unf), .SP_OUT(a_sp), .EMPTY(a_empty), .FULL(a_full), .SCR_ADDR(a_addr),
    .SCR_WE(a_we), .SCR_DATA_OUT(a_wdata), .SCR_DATA_IN(a_rdata), .STATE_DBG(a_state)
  );
  assign a_rdata = mem_a[a_addr];
  always @(posedge clk) if (a_we) mem_a[a_addr] <= a_wdata;

  // ---------------- DUT B (STACK_DEPTH = 4) ----------------
  logic       b_op_ready, b_resp_valid, b_done, b_ovf, b_unf, b_empty, b_full, b_we;
  logic [9:0] b_resp_data, b_wdata, b_rdata;
  logic [7:0] b_sp, b_addr;
  logic [1:0] b_state;
  logic [9:0] mem_b [256];

  scr_stack_ctrl #(.STACK_DEPTH(4)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .OP_VALID(op_valid), .OP(op), .OP_READY(b_op_ready),
    .PUSH_DATA(push_data), .SP_IN(sp_in), .RESP_VALID(b_resp_valid),
    .RESP_READY(resp_ready), .RESP_DATA(b_resp_data), .DONE(b_done), .OVF(b_ovf),
    .UNF(b_unf), .SP_OUT(b_sp), .EMPTY(b_empty), .FULL(b_full), .SCR_ADDR(b_addr),
    .SCR_WE(b_we), .SCR_DATA_OUT(b_wdata), .SCR_DATA_IN(b_rdata), .STATE_DBG(b_state)
  );
  assign b_rdata = mem_b[b_addr];
  always @(posedge clk) if (b_we) mem_b[b_addr] <= b_wdata;

  // ---------------- observed outputs of the selected DUT ----------------
  wire       op_ready   = sel ? b_op_ready   : a_op_ready;
  wire       resp_valid = sel ? b_resp_valid : a_resp_valid;
  wire       done       = sel ? b_done       : a_done;
  wire       ovf        = sel ? b_ovf        : a_ovf;
  wire       unf        = sel ? b_unf        : a_unf;
  wire       empty      = sel ? b_empty      : a_empty;
  wire       full       = sel ? b_full       : a_full;
  wire       scr_we     = sel ? b_we         : a_we;
  wire [9:0] resp_data  = sel ? b_resp_data  : a_resp_data;
  wire [9:0] wdata      = sel ? b_wdata      : a_wdata;
  wire [7:0] sp_out     = sel ? b_sp         : a_sp;
  wire [7:0] scr_addr   = sel ? b_addr       : a_addr;
  wire [1:0] state_dbg  = sel ? b_state      : a_state;

  // ---------------- model and scoreboard ----------------
  logic [7:0] model_sp;
  logic [9:0] stk[$];
  logic [9:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_occ();
    logic [7:0] o;
    o = 8'h00 - model_sp;
    return o;
  endfunction

  function automatic int depth_now();
    return sel ? 4 : 255;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_all();
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    model_sp = 8'h00;
    stk.delete();
    exp_q.delete();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check("op_ready_timeout", 32'(op_ready), 32'd1);
  endtask

  task automatic push_op(input logic [9:0] d);
    logic [7:0] nsp;
    wait_ready();
    op_valid = 1'b1; op = 2'b00; push_data = d;
    @(negedge clk);
    op_valid = 1'b0;
    if (int'(model_occ()) >= depth_now()) begin
      check("ovf_pulse", 32'(ovf), 32'd1);
      check("ovf_no_we", 32'(scr_we), 32'd0);
      check("ovf_sp", 32'(sp_out), 32'(model_sp));
      check("ovf_ready", 32'(op_ready), 32'd1);
      @(negedge clk);
      check("ovf_clear", 32'(ovf), 32'd0);
      check("ovf_no_we2", 32'(scr_we), 32'd0);
    end else begin
      nsp = model_sp - 8'd1;
      check("push_we", 32'(scr_we), 32'd1);
      check("push_addr", 32'(scr_addr), 32'(nsp));
      check("push_wdata", 32'(wdata), 32'(d));
      check("push_busy", 32'(op_ready), 32'd0);
      model_sp = nsp;
      stk.push_back(d);
      @(negedge clk);
      check("push_done", 32'(done), 32'd1);
      check("push_sp", 32'(sp_out), 32'(model_sp));
      check("push_we_off", 32'(scr_we), 32'd0);
      check("push_empty", 32'(empty), 32'd0);
    end
  endtask

  task automatic pop_op(input int hold);
    logic [7:0] nsp;
    wait_ready();
    op_valid = 1'b1; op = 2'b01;
    @(negedge clk);
    op_valid = 1'b0;
    if (model_occ() == 8'h00) begin
      exp_q.push_back(10'h000);
      check("unf_pulse", 32'(unf), 32'd1);
      check("unf_resp_valid", 32'(resp_valid), 32'd1);
      check("unf_sp", 32'(sp_out), 32'(model_sp));
      check("unf_no_we", 32'(scr_we), 32'd0);
    end else begin
      exp_q.push_back(stk.pop_back());
      check("pop_rd_addr", 32'(scr_addr), 32'(model_sp));
      check("pop_rd_we", 32'(scr_we), 32'd0);
      check("pop_rd_busy", 32'(op_ready), 32'd0);
      check("pop_rd_valid", 32'(resp_valid), 32'd0);
      nsp = model_sp + 8'd1;
      model_sp = nsp;
      @(negedge clk);
      check("pop_resp_valid", 32'(resp_valid), 32'd1);
      check("pop_sp", 32'(sp_out), 32'(model_sp));
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", 32'(resp_data), 32'(exp_q[0]));
      check("hold_busy", 32'(op_ready), 32'd0);
      check("hold_no_we", 32'(scr_we), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_released", 32'(resp_valid), 32'd0);
    check("resp_idle_ready", 32'(op_ready), 32'd1);
    check("resp_unf_clear", 32'(unf), 32'd0);
    check("resp_no_we", 32'(scr_we), 32'd0);
  endtask

  task automatic load_sp_op(input logic [7:0] v);
    wait_ready();
    op_valid = 1'b1; op = 2'b10; sp_in = v;
    @(negedge clk);
    op_valid = 1'b0;
    model_sp = v;
    stk.delete();
    check("load_done", 32'(done), 32'd1);
    check("load_sp", 32'(sp_out), 32'(v));
    check("load_ready", 32'(op_ready), 32'd1);
    check("load_no_we", 32'(scr_we), 32'd0);
  endtask

  task automatic nop_op();
    wait_ready();
    op_valid = 1'b1; op = 2'b11;
    @(negedge clk);
    op_valid = 1'b0;
    check("nop_sp", 32'(sp_out), 32'(model_sp));
    check("nop_ready", 32'(op_ready), 32'd1);
    check("nop_done", 32'(done), 32'd0);
    check("nop_no_we", 32'(scr_we), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_all();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_sp", 32'(sp_out), 32'h00);
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_we", 32'(scr_we), 32'd0);
    check("rst_addr", 32'(scr_addr), 32'h00);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_pulses", {29'd0, done, ovf, unf}, 32'd0);

    // single push
    push_op(10'h155);

    // LIFO order
    reset_all();
    push_op(10'h001);
    push_op(10'h002);
    pop_op(0);
    pop_op(0);
    check("lifo_sp", 32'(sp_out), 32'h00);
    check("lifo_empty", 32'(empty), 32'd1);

    // underflow
    pop_op(0);
    check("unf_final_sp", 32'(sp_out), 32'h00);

    // consumer back-pressure
    push_op(10'h0AA);
    pop_op(5);

    // reserved opcode
    nop_op();

    // random traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0, 1: push_op(10'($urandom_range(0, 1023)));
        default: pop_op(int'($urandom_range(0, 2)));
      endcase
    end
    while (stk.size() > 0) pop_op(0);
    check("drain_empty", 32'(empty), 32'd1);

    // LOAD_SP then push
    load_sp_op(8'hF0);
    push_op(10'h3FF);
    check("load_push_sp", 32'(sp_out), 32'hEF);

    // reset during PUSH_WR
    reset_all();
    wait_ready();
    op_valid = 1'b1; op = 2'b00; push_data = 10'h2A5;
    @(negedge clk);
    op_valid = 1'b0;
    check("mid_push_we", 32'(scr_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drop_we", 32'(scr_we), 32'd0);
    check("rst_drop_sp", 32'(sp_out), 32'h00);
    check("rst_drop_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_sp = 8'h00;
    stk.delete();
    @(negedge clk);
    check("post_rst_sp", 32'(sp_out), 32'h00);
    check("post_rst_done", 32'(done), 32'd0);

    // depth-4 instance: fill and overflow
    sel = 1'b1;
    reset_all();
    for (int i = 0; i < 4; i++) begin
      check("d4_not_full", 32'(full), 32'd0);
      push_op(10'(10'h100 + i));
    end
    check("d4_full", 32'(full), 32'd1);
    push_op(10'h3C3);
    check("d4_sp", 32'(sp_out), 32'hFC);
    pop_op(0);
    check("d4_not_full_after_pop", 32'(full), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
